// File: rtl/prbs7_capture_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : prbs7_capture_checker
// Purpose  : Self-synchronising PRBS7 (x^7+x^6+1) checker with lock tracking
//            and a saturating error counter. Optional macro CHK_IN_SYNC_EN
//            inserts two input flops ahead of the checker.
// Revision : 1.0 - initial release
// ============================================================================
module prbs7_capture_checker #(
    parameter int ERR_CNT_W = 16,
    parameter int LOCK_CNT  = 8,
    parameter int LOSS_CNT  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 d_in_i,
    output logic                 locked_o,
    output logic                 err_flag_o,
    output logic [ERR_CNT_W-1:0] err_count_o
);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]           LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [3:0]           LOSS_LAST = 4'(LOSS_CNT - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_ONE   = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic w_bit;

`ifdef CHK_IN_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else if (en_i) begin
            sync_q <= {sync_q[0], d_in_i};
        end
    end

    assign w_bit = sync_q[1];
`else
    assign w_bit = d_in_i;
`endif

    state_t               state_q, state_d;
    logic [6:0]           sr_q, sr_d;
    logic [2:0]           fill_q, fill_d;
    logic [7:0]           match_q, match_d;
    logic [3:0]           miss_q, miss_d;
    logic                 locked_q, locked_d;
    logic                 err_flag_q, err_flag_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic       w_expected;
    logic       w_mismatch;
    logic [6:0] w_sr_fill;

    assign w_expected = sr_q[6] ^ sr_q[5];
    assign w_mismatch = w_bit ^ w_expected;
    assign w_sr_fill  = {sr_q[5:0], w_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SEED;
            sr_q       <= 7'd0;
            fill_q     <= 3'd0;
            match_q    <= 8'd0;
            miss_q     <= 4'd0;
            locked_q   <= 1'b0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            fill_q     <= fill_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            locked_q   <= locked_d;
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        fill_d     = fill_q;
        match_d    = match_q;
        miss_d     = miss_q;
        locked_d   = locked_q;
        err_flag_d = 1'b0;
        err_cnt_d  = err_cnt_q;

        if (en_i) begin
            case (state_q)
                ST_SEED: begin
                    sr_d = w_sr_fill;
                    if (fill_q == 3'd6) begin
                        fill_d = 3'd0;
                        // An all-zero history is a dead line, not a PRBS seed.
                        if (w_sr_fill != 7'd0) begin
                            state_d = ST_ACQ;
                            match_d = 8'd0;
                        end
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end
                ST_ACQ: begin
                    sr_d = w_sr_fill;
                    if (!w_mismatch) begin
                        if (match_q == LOCK_LAST) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            match_d  = 8'd0;
                            miss_d   = 4'd0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end else begin
                        state_d = ST_SEED;
                        fill_d  = 3'd0;
                        match_d = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    // Regenerate locally so a corrupted bit never enters the history.
                    sr_d = {sr_q[5:0], w_expected};
                    if (w_mismatch) begin
                        err_flag_d = 1'b1;
                        if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_ONE;
                        end
                        if (miss_q == LOSS_LAST) begin
                            state_d  = ST_SEED;
                            locked_d = 1'b0;
                            fill_d   = 3'd0;
                            miss_d   = 4'd0;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end else begin
                        miss_d = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_SEED;
                end
            endcase
        end

        if (clr_i) begin
            err_cnt_d = '0;
        end
    end

    assign locked_o    = locked_q;
    assign err_flag_o  = err_flag_q;
    assign err_count_o = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs7_capture_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_prbs7_capture_checker
// Purpose  : Directed self-checking bench for prbs7_capture_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs7_capture_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        d_in;
    logic        locked;
    logic        err_flag;
    logic [15:0] err_count;
    logic        locked4;
    logic        err_flag4;
    logic [3:0]  err_count4;

    int          checks = 0;
    int          errors = 0;
    logic [6:0]  g;

    always #5 clk = ~clk;

    prbs7_capture_checker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .clr_i       (clr),
        .d_in_i      (d_in),
        .locked_o    (locked),
        .err_flag_o  (err_flag),
        .err_count_o (err_count)
    );

    prbs7_capture_checker #(.ERR_CNT_W(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .clr_i       (clr),
        .d_in_i      (d_in),
        .locked_o    (locked4),
        .err_flag_o  (err_flag4),
        .err_count_o (err_count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b);
        d_in = b;
        @(posedge clk);
        #1;
    endtask

    // Reference PRBS7 generator; inv corrupts the transmitted bit only.
    task automatic send_gen(input logic inv);
        logic b;
        b = g[6] ^ g[5];
        g = {g[5:0], b};
        send(b ^ inv);
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) send_gen(1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        d_in  = 1'b0;
        g     = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked",  32'(locked),     32'd0);
        chk("rst_flag",    32'(err_flag),   32'd0);
        chk("rst_count",   32'(err_count),  32'd0);
        chk("rst_count4",  32'(err_count4), 32'd0);
        rst_n = 1'b1;

        // Dead all-zero line never locks
        en = 1'b1;
        for (int i = 0; i < 50; i++) send(1'b0);
        chk("dead_locked", 32'(locked),    32'd0);
        chk("dead_count",  32'(err_count), 32'd0);

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean stream: lock exactly on the 15th bit
        g = 7'h7F;
        send_clean(14);
        chk("lock_pre15",  32'(locked), 32'd0);
        send_clean(1);
        chk("lock_at15",   32'(locked), 32'd1);
        send_clean(985);
        chk("clean_locked", 32'(locked),    32'd1);
        chk("clean_count",  32'(err_count), 32'd0);
        chk("clean_flag",   32'(err_flag),  32'd0);

        // Single error
        send_clean(199);
        send_gen(1'b1);
        chk("single_flag",   32'(err_flag),  32'd1);
        chk("single_count",  32'(err_count), 32'd1);
        chk("single_locked", 32'(locked),    32'd1);
        send_clean(1);
        chk("single_flag_off", 32'(err_flag), 32'd0);
        send_clean(50);
        chk("single_count_hold", 32'(err_count), 32'd1);
        chk("single_still_lock", 32'(locked),    32'd1);

        // Burst of LOSS_CNT errors drops lock
        clr = 1'b1;
        send_clean(1);
        clr = 1'b0;
        chk("clr_count", 32'(err_count), 32'd0);
        repeat (3) send_gen(1'b1);
        chk("burst3_locked", 32'(locked),    32'd1);
        chk("burst3_count",  32'(err_count), 32'd3);
        send_gen(1'b1);
        chk("burst4_locked", 32'(locked),    32'd0);
        chk("burst4_count",  32'(err_count), 32'd4);
        chk("burst4_flag",   32'(err_flag),  32'd1);
        send_clean(14);
        chk("relock_pre15", 32'(locked), 32'd0);
        send_clean(1);
        chk("relock_at15",  32'(locked), 32'd1);
        chk("relock_count", 32'(err_count), 32'd4);

        // Saturation with 4-bit counter
        clr = 1'b1;
        send_clean(1);
        clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send_gen(1'b1);
            send_clean(3);
        end
        chk("sat_count4", 32'(err_count4), 32'hF);
        chk("sat_count16", 32'(err_count), 32'd20);
        chk("sat_locked",  32'(locked),    32'd1);
        clr = 1'b1;
        send_clean(1);
        clr = 1'b0;
        chk("sat_clr4",  32'(err_count4), 32'd0);
        chk("sat_clr16", 32'(err_count),  32'd0);

        // clr coinciding with an error: clear wins, flag still pulses
        clr = 1'b1;
        send_gen(1'b1);
        clr = 1'b0;
        chk("clrerr_count", 32'(err_count), 32'd0);
        chk("clrerr_flag",  32'(err_flag),  32'd1);

        // en=0 freezes the checker
        send_clean(5);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(1'($urandom_range(0, 1)));
            chk("freeze_flag", 32'(err_flag), 32'd0);
        end
        chk("freeze_locked", 32'(locked),    32'd1);
        chk("freeze_count",  32'(err_count), 32'd0);
        en = 1'b1;
        send_clean(30);
        chk("resume_count",  32'(err_count), 32'd0);
        chk("resume_locked", 32'(locked),    32'd1);

        // Asynchronous reset mid-LOCKED
        send_clean(3);
        send_gen(1'b1);
        chk("prerst_flag",  32'(err_flag),  32'd1);
        chk("prerst_count", 32'(err_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_locked", 32'(locked),    32'd0);
        chk("arst_flag",   32'(err_flag),  32'd0);
        chk("arst_count",  32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_clean(14);
        chk("arst_relock_pre15", 32'(locked), 32'd0);
        send_clean(1);
        chk("arst_relock_at15",  32'(locked), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
